// File: rtl/shift_arb.sv
// Two-requester arbiter feeding one shared 16-bit rotate/shift unit and a 1-deep result register.
// Build option: define SHIFT_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no last-grant pointer).
module shift_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_cnt,
  input  logic [1:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_cnt,
  input  logic [1:0]  req1_op,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [15:0] res_out,
  output logic        res_id,
  input  logic        res_ready
);

  localparam int DATA_W = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_p0, state_nxt;
  logic [DATA_W-1:0]   data_p0;
  logic                id_p0;
  logic                vld_p0;
  logic                slot_free;
  logic                grant0, grant1;
  logic                accept;
  logic [DATA_W-1:0]   sel_in;
  logic [3:0]          sel_cnt;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   shifted;

  // Rotates index into the operand duplicated side by side; cnt=0 yields the operand for every op.
  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] x,
                                                 input logic [3:0] cnt,
                                                 input logic [1:0] op);
    logic [2*DATA_W-1:0] dbl;
    logic [4:0]          hi_l, hi_r;
    dbl  = {x, x};
    hi_l = 5'd31 - {1'b0, cnt};
    hi_r = 5'd15 + {1'b0, cnt};
    case (op)
      2'b00:   shift_op = dbl[hi_l -: DATA_W];
      2'b01:   shift_op = x << cnt;
      2'b10:   shift_op = dbl[hi_r -: DATA_W];
      default: shift_op = x >> cnt;
    endcase
  endfunction

  assign vld_p0    = (state_p0 == FULL);
  assign slot_free = !vld_p0 || res_ready;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
  assign grant1 = req1_valid && !req0_valid;
`else
  // last_grant_p0 = 1 means requester 1 won the most recent accept.
  logic last_grant_p0;

  assign grant0 = req0_valid && (!req1_valid || last_grant_p0);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_p0);

  always_ff @(posedge clk) begin
    if (rst)
      last_grant_p0 <= 1'b1;
    else if (accept)
      last_grant_p0 <= req1_ready;
  end
`endif

  assign req0_ready = grant0 && slot_free && !rst;
  assign req1_ready = grant1 && slot_free && !rst;
  assign accept     = req0_ready || req1_ready;

  assign sel_in  = req1_ready ? req1_in  : req0_in;
  assign sel_cnt = req1_ready ? req1_cnt : req0_cnt;
  assign sel_op  = req1_ready ? req1_op  : req0_op;
  assign shifted = shift_op(sel_in, sel_cnt, sel_op);

  always_ff @(posedge clk) begin
    if (rst)
      state_p0 <= EMPTY;
    else
      state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (accept) state_nxt = FULL;
               else if (res_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p0: result register loaded on accept, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
      id_p0   <= 1'b0;
    end else if (accept) begin
      data_p0 <= shifted;
      id_p0   <= req1_ready;
    end
  end

  assign res_valid = vld_p0;
  assign res_out   = data_p0;
  assign res_id    = id_p0;

endmodule

// File: tb/tb_shift_arb.sv
// Directed bench for shift_arb: reset, all ops, cnt boundaries, arbitration, back-pressure, reset while full.
module tb_shift_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_in, req1_in;
  logic [3:0]  req0_cnt, req1_cnt;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic [15:0] res_out;
  logic        res_id;
  logic        res_ready;

  int total  = 0;
  int passed = 0;

  shift_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_in(req0_in), .req0_cnt(req0_cnt), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_in(req1_in), .req1_cnt(req1_cnt), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_out(res_out), .res_id(res_id), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [15:0] d, input logic id);
    chk({tag, "_valid"}, {15'd0, res_valid}, {15'd0, v});
    chk({tag, "_out"}, res_out, d);
    chk({tag, "_id"}, {15'd0, res_id}, {15'd0, id});
  endtask

  logic [15:0] ops_exp [4];
  logic        rr_id   [4];
  logic [15:0] rr_out  [4];

  initial begin
    ops_exp = '{16'h00FF, 16'h00F0, 16'hFF00, 16'h0F00};
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    rr_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
    rr_out = '{16'h0002, 16'h0002, 16'h0002, 16'h0002};
`else
    rr_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    rr_out = '{16'h0002, 16'h0004, 16'h0002, 16'h0004};
`endif

    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_in = 16'h0; req0_cnt = 4'd0; req0_op = 2'd0;
    req1_valid = 1'b1; req1_in = 16'h0; req1_cnt = 4'd0; req1_op = 2'd0;
    #1;
    chk("rst_ready0", {15'd0, req0_ready}, 16'd0);
    chk("rst_ready1", {15'd0, req1_ready}, 16'd0);
    step();
    step();
    chk_res("reset", 1'b0, 16'h0000, 1'b0);
    chk("rst_ready0_hold", {15'd0, req0_ready}, 16'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    #1;

    // Rotate left of 8001 by 1
    req0_valid = 1'b1; req0_in = 16'h8001; req0_cnt = 4'd1; req0_op = 2'b00;
    #1;
    chk("rol1_ready0", {15'd0, req0_ready}, 16'd1);
    chk("rol1_ready1", {15'd0, req1_ready}, 16'd0);
    step();
    req0_valid = 1'b0;
    chk_res("rol1", 1'b1, 16'h0003, 1'b0);

    // All four ops on F00F by 4 through requester 1, back to back
    req1_valid = 1'b1; req1_in = 16'hF00F; req1_cnt = 4'd4;
    for (int i = 0; i < 4; i++) begin
      req1_op = 2'(i);
      step();
      chk_res($sformatf("op%0d", i), 1'b1, ops_exp[i], 1'b1);
    end
    req1_valid = 1'b0;

    // Count boundaries: cnt=0 passes through, cnt=15 rotate left equals rotate right by 1
    req0_valid = 1'b1; req0_in = 16'hA5C3; req0_cnt = 4'd0; req0_op = 2'b10;
    step();
    chk_res("cnt0_ror", 1'b1, 16'hA5C3, 1'b0);
    req0_op = 2'b11;
    step();
    chk_res("cnt0_shr", 1'b1, 16'hA5C3, 1'b0);
    req0_in = 16'h8001; req0_cnt = 4'd15; req0_op = 2'b00;
    step();
    chk_res("rol15", 1'b1, 16'hC000, 1'b0);
    req0_op = 2'b01;
    step();
    chk_res("shl15", 1'b1, 16'h8000, 1'b0);
    req0_valid = 1'b0;
    step();
    chk("drain_valid", {15'd0, res_valid}, 16'd0);

    // Fill with 1234 under back-pressure, then reset while full
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_in = 16'h1234; req0_cnt = 4'd0; req0_op = 2'b00;
    step();
    chk_res("full1234", 1'b1, 16'h1234, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    chk_res("rst_full", 1'b0, 16'h0000, 1'b0);

    // Both requesters contend continuously
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_in = 16'h0001; req0_cnt = 4'd1; req0_op = 2'b01;
    req1_valid = 1'b1; req1_in = 16'h0001; req1_cnt = 4'd2; req1_op = 2'b01;
    #1;
    chk("tie_ready0", {15'd0, req0_ready}, 16'd1);
    chk("tie_ready1", {15'd0, req1_ready}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_res($sformatf("rr%0d", i), 1'b1, rr_out[i], rr_id[i]);
    end

    // Consumer stalls for 3 cycles with both requesters still pending
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_ready0", i), {15'd0, req0_ready}, 16'd0);
      chk($sformatf("stall%0d_ready1", i), {15'd0, req1_ready}, 16'd0);
      step();
      chk_res($sformatf("stall%0d", i), 1'b1, rr_out[3], rr_id[3]);
    end
    res_ready = 1'b1;
    #1;
    chk("release_ready0", {15'd0, req0_ready}, 16'd1);
    chk("release_ready1", {15'd0, req1_ready}, 16'd0);
    step();
    chk_res("release", 1'b1, 16'h0002, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("final_empty", {15'd0, res_valid}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 16 bits, count at 4 bits, op at 2 bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1, requester 0 has an operation pending.
REQ-005 The block SHALL have port req0_in, input, 16, requester 0 operand.
REQ-006 The block SHALL have port req0_cnt, input, 4, requester 0 shift/rotate amount.
REQ-007 The block SHALL have port req0_op, input, 2, requester 0 operation select.
REQ-008 The block SHALL have port req0_ready, output, 1, requester 0 accepted this cycle when high with req0_valid.
REQ-009 The block SHALL have ports req1_valid, req1_in, req1_cnt, req1_op and req1_ready, identical to REQ-004 to REQ-008, for requester 1.
REQ-010 The block SHALL have port res_valid, output, 1, result register holds a valid result.
REQ-011 The block SHALL have port res_out, output, 16, shifted result.
REQ-012 The block SHALL have port res_id, output, 1, requester index that produced res_out.
REQ-013 The block SHALL have port res_ready, input, 1, consumer takes the result when high with res_valid.

Function
REQ-014 Op encoding SHALL be: 00 rotate left; 01 shift left logical (zero fill); 10 rotate right; 11 shift right logical (zero fill).
REQ-015 The block SHALL contain one combinational 16-bit shifter, shared by both requesters.
REQ-016 Output register state SHALL be EMPTY (res_valid=0) or FULL (res_valid=1).
REQ-017 Slot free SHALL be defined as (!res_valid | res_ready).
REQ-018 Grant SHALL be combinational from req0_valid, req1_valid and the last-grant pointer.
REQ-019 Only one valid requester: that requester SHALL be granted.
REQ-020 Both requesters valid: the requester not granted most recently SHALL be granted (round-robin).
REQ-021 reqN_ready SHALL be (grantN & slot free); at most one ready SHALL be high in a cycle.
REQ-022 Readiness SHALL NOT depend on reqN_valid of the same port beyond the grant.
REQ-023 On accept at edge N, res_out and res_id SHALL be loaded and res_valid SHALL be 1 after edge N; latency is 1 cycle.
REQ-024 Accept and result take in the same cycle SHALL reload the register with res_valid staying 1, giving one result per cycle.
REQ-025 Result take without accept SHALL go FULL to EMPTY.
REQ-026 In FULL with res_ready=0, res_out, res_id and res_valid SHALL hold, and both readies SHALL be 0.
REQ-027 The last-grant pointer SHALL update only on an accept.
REQ-028 cnt=0 SHALL pass the operand unchanged for all ops.

Reset
REQ-029 With rst high at a rising edge, after that edge res_valid SHALL be 0, res_out 16'h0000, res_id 0, and last-grant pointer 1, so requester 0 wins the first tie.
REQ-030 Reset asserted while FULL or during an accept SHALL discard the held result and the accepted operation.
REQ-031 While rst is high, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-032 Macro SHIFT_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win ties and the last-grant pointer SHALL be absent.
REQ-033 Macro SHIFT_ARB_FIXED_PRIO_EN undefined: arbitration SHALL be round-robin as in REQ-020.

Verification
REQ-034 Rotate left: req0 in=16'h8001, cnt=1, op=00, res_ready=1 -> next cycle res_valid=1, res_out=16'h0003, res_id=0.
REQ-035 All four ops on in=16'hF00F, cnt=4 -> res_out 16'h00FF (00), 16'h00F0 (01), 16'hFF00 (10), 16'h0F00 (11).
REQ-036 Both valid continuously for 4 cycles, res_ready=1 -> res_id sequence 0,1,0,1; with SHIFT_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
REQ-037 res_ready=0 for 3 cycles while FULL -> res_out stable, both readies 0; res_ready=1 -> next queued request accepted that cycle.
REQ-038 rst pulsed while FULL with res_out=16'h1234 -> next cycle res_valid=0, res_out=16'h0000; first tie after reset granted to req0.
